wb_port_sched: RTL and testbench
================================

Name: wb_port_sched

Overview:
- Schedules the single register-file write port between ALU results and memory load returns.
- Drives the 1-bit write-mux select (Load: 0 = ALU path on Source1, 1 = memory data on Source2), register-file write enable and write address.
- Holds one colliding ALU write in a 1-entry buffer and stalls decode on load hazards.
- Sits between decode/execute and the register file; at most one load is outstanding.

Parameters:
- ADDR_W, 3, register address width.
- DATA_W, 8, datapath width.
- LOAD_LAT, 2, cycles from load issue to data valid at Source2; legal range 1..7.

Ports:
- CLK  in  1  clock, rising edge.
- RST_n  in  1  asynchronous active-low reset.
- alu_wr_valid  in  1  ALU result ready for write-back this cycle.
- alu_wr_addr  in  ADDR_W  ALU destination register.
- alu_wr_data  in  DATA_W  ALU result.
- load_issue  in  1  load instruction issued to memory this cycle.
- load_dst  in  ADDR_W  load destination register.
- rd_valid  in  1  decode instruction reads source registers.
- rd_addr_a  in  ADDR_W  decode source register A.
- rd_addr_b  in  ADDR_W  decode source register B.
- Load  out  1  write-mux select.
- wb_alu_data  out  DATA_W  data to mux Source1 (live ALU data or buffered data).
- wr_en  out  1  register-file write enable.
- wr_addr  out  ADDR_W  register-file write address.
- stall  out  1  upstream must hold its inputs while this is high.

Behaviour:
- Reset (async, RST_n=0):
  - state=IDLE, counter=0, buffer empty, pend_dst=0.
  - Outputs Load=0, wr_en=0, wr_addr=0, wb_alu_data=0, stall=0.
  - Reset mid-load discards the pending load; there is no write on release.
- FSM states:
  - IDLE: no load pending.
  - WAIT: counting to LOAD_LAT.
  - RET: load data valid this cycle.
- FSM transitions:
  - IDLE -> WAIT on an accepted load_issue. Latch pend_dst=load_dst and set counter=LOAD_LAT-1.
  - If LOAD_LAT=1, IDLE -> RET directly.
  - WAIT: counter decrements each cycle; WAIT -> RET when counter reaches 1.
  - RET -> IDLE unconditionally.
  - busy = (state != IDLE), so busy is also true in RET.
- stall (combinational) is high when any of these holds:
  - buffer full;
  - busy & load_issue (second outstanding load);
  - busy & rd_valid & (rd_addr_a==pend_dst | rd_addr_b==pend_dst) (RAW hazard);
  - busy & alu_wr_valid & alu_wr_addr==pend_dst (WAW hazard).
- While stall=1, alu_wr_valid and load_issue are ignored (not accepted, not buffered).
- Write-port priority each cycle, zero latency (combinational outputs from registered state):
  1. RET: Load=1, wr_en=1, wr_addr=pend_dst. An accepted ALU write in the same cycle is captured into the buffer (addr+data).
  2. Buffer full: Load=0, wr_en=1, wr_addr=buf_addr, wb_alu_data=buf_data. Buffer empties at the clock edge.
  3. Accepted alu_wr_valid: Load=0, wr_en=1, wr_addr=alu_wr_addr, wb_alu_data=alu_wr_data.
  4. Otherwise wr_en=0, Load=0, wr_addr and wb_alu_data hold their last values.
- Buffer drain never collides with RET, because only one load is in flight and a new load cannot be accepted during RET.
- wr_en is never high for two sources in one cycle; at most one register write per cycle.
- No arithmetic beyond the counter. The counter is clog2(LOAD_LAT+1) bits and never wraps.

Decomposition:
- Shared package (cpu_pkg): wb_state_t enum {IDLE, WAIT, RET}; constants SEL_ALU=1'b0 and SEL_MEM=1'b1 for the mux select.
- One natural sub-module: wb_hold_buf, a 1-entry addr+data register with full flag, load and drain strobes, and async active-low reset.

Test Plan:
- Reset while in WAIT (load to r3 issued, RST_n low one cycle) -> all outputs 0, state IDLE; no wr_en for r3 afterwards.
- ALU write r2=0x5A with no load -> same cycle wr_en=1, wr_addr=2, Load=0, wb_alu_data=0x5A, stall=0.
- load_issue dst=r4 at cycle 0 (LOAD_LAT=2) -> cycle 2: Load=1, wr_en=1, wr_addr=4; cycle 3: wr_en=0.
- Load r4 at cycle 0; ALU write r1=0x33 at cycle 2 ->
  - cycle 2: Load=1, wr_addr=4;
  - cycle 3: stall=1, Load=0, wr_addr=1, wb_alu_data=0x33;
  - cycle 4: stall=0.
- Load r4 pending; rd_valid with rd_addr_b=4 at cycle 1 -> stall=1 at cycles 1-2, stall=0 at cycle 3.
- Load r4 pending; second load_issue, or ALU write to r4, at cycle 1 -> stall=1 until after RET, the request is not accepted, and no wr_en to r4 precedes the load write.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the write-back port scheduler
//
// Holds the load-tracking FSM state encoding and the write-mux select values.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RET  = 2'd2
    } wb_state_t;

    localparam logic SEL_ALU = 1'b0;
    localparam logic SEL_MEM = 1'b1;

endpackage

// File: rtl/wb_hold_buf.sv
// rtl/wb_hold_buf.sv - single-entry address+data holding register
//
// Parks one ALU write that lost the write port to a load return.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   load_i             capture addr_i/data_i and mark full
//   drain_i            clear full (entry consumed this cycle)
//   addr_i, data_i     entry to capture
//   full_o             entry valid
//   addr_o, data_o     held entry
module wb_hold_buf #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              full_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              full_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else if (load_i) begin
            full_q <= 1'b1;
            addr_q <= addr_i;
            data_q <= data_i;
        end else if (drain_i) begin
            full_q <= 1'b0;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign data_o = data_q;

endmodule

// File: rtl/wb_port_sched.sv
// rtl/wb_port_sched.sv - register-file write-port scheduler for ALU and load returns
//
// Arbitrates the single register-file write port between load returns (highest),
// a buffered ALU write, and a live ALU write; stalls decode on load hazards.
// Ports:
//   CLK, RST_n                        clock, asynchronous active-low reset
//   alu_wr_valid/addr/data            ALU write-back request
//   load_issue, load_dst              load issued to memory and its destination
//   rd_valid, rd_addr_a, rd_addr_b    decode source-register reads
//   Load                              write-mux select (0 ALU, 1 memory)
//   wb_alu_data                       data presented on the ALU mux input
//   wr_en, wr_addr                    register-file write strobe and address
//   stall                             upstream must hold its inputs
module wb_port_sched
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8,
    parameter int LOAD_LAT = 2
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              alu_wr_valid,
    input  logic [ADDR_W-1:0] alu_wr_addr,
    input  logic [DATA_W-1:0] alu_wr_data,
    input  logic              load_issue,
    input  logic [ADDR_W-1:0] load_dst,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              Load,
    output logic [DATA_W-1:0] wb_alu_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              stall
);

    localparam int               CNT_W    = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    wb_state_t         state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] pend_dst_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              busy;
    logic              ret;
    logic              alu_acc;
    logic              load_acc;
    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [DATA_W-1:0] buf_data;

    assign busy = (state_q != IDLE);
    assign ret  = (state_q == RET);

    assign stall = buf_full
                 | (busy & load_issue)
                 | (busy & rd_valid & ((rd_addr_a == pend_dst_q) | (rd_addr_b == pend_dst_q)))
                 | (busy & alu_wr_valid & (alu_wr_addr == pend_dst_q));

    assign alu_acc  = alu_wr_valid & ~stall;
    // Any busy state stalls a load, so an accepted load always arrives in IDLE.
    assign load_acc = load_issue & ~stall;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_dst_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_acc) begin
                        pend_dst_q <= load_dst;
                        cnt_q      <= CNT_INIT;
                        state_q    <= (LOAD_LAT == 1) ? RET : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_ONE) begin
                        cnt_q   <= '0;
                        state_q <= RET;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                RET:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // A buffered write can only exist in IDLE (it is filled during RET and
    // blocks new loads), so draining never competes with a load return.
    wb_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk_i   (CLK),
        .rst_ni  (RST_n),
        .load_i  (ret & alu_acc),
        .drain_i (buf_full & ~ret),
        .addr_i  (alu_wr_addr),
        .data_i  (alu_wr_data),
        .full_o  (buf_full),
        .addr_o  (buf_addr),
        .data_o  (buf_data)
    );

    always_comb begin
        Load        = SEL_ALU;
        wr_en       = 1'b0;
        wr_addr     = wr_addr_q;
        wb_alu_data = wdata_q;
        if (ret) begin
            Load    = SEL_MEM;
            wr_en   = 1'b1;
            wr_addr = pend_dst_q;
        end else if (buf_full) begin
            wr_en       = 1'b1;
            wr_addr     = buf_addr;
            wb_alu_data = buf_data;
        end else if (alu_acc) begin
            wr_en       = 1'b1;
            wr_addr     = alu_wr_addr;
            wb_alu_data = alu_wr_data;
        end
    end

    // Remember the last driven address/data so idle cycles hold them.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            wr_addr_q <= '0;
            wdata_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr;
            wdata_q   <= wb_alu_data;
        end
    end

endmodule

// File: tb/tb_wb_port_sched.sv
// tb/tb_wb_port_sched.sv - self-checking bench for wb_port_sched
module tb_wb_port_sched;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 8;
    localparam int LOAD_LAT = 2;

    logic              CLK = 1'b0;
    logic              RST_n = 1'b0;
    logic              alu_wr_valid = 1'b0;
    logic [ADDR_W-1:0] alu_wr_addr = '0;
    logic [DATA_W-1:0] alu_wr_data = '0;
    logic              load_issue = 1'b0;
    logic [ADDR_W-1:0] load_dst = '0;
    logic              rd_valid = 1'b0;
    logic [ADDR_W-1:0] rd_addr_a = '0;
    logic [ADDR_W-1:0] rd_addr_b = '0;
    logic              Load;
    logic [DATA_W-1:0] wb_alu_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              stall;

    wb_port_sched #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .LOAD_LAT (LOAD_LAT)
    ) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .alu_wr_valid (alu_wr_valid),
        .alu_wr_addr  (alu_wr_addr),
        .alu_wr_data  (alu_wr_data),
        .load_issue   (load_issue),
        .load_dst     (load_dst),
        .rd_valid     (rd_valid),
        .rd_addr_a    (rd_addr_a),
        .rd_addr_b    (rd_addr_b),
        .Load         (Load),
        .wb_alu_data  (wb_alu_data),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .stall        (stall)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: absolute cycle numbers and a queue of parked writes.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    int                cyc;
    bit                pend_v;
    logic [ADDR_W-1:0] pend_dst;
    int                ret_cyc;
    wr_t               bufq[$];
    logic [ADDR_W-1:0] last_addr;
    logic [DATA_W-1:0] last_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cyc       = 0;
        pend_v    = 1'b0;
        pend_dst  = '0;
        ret_cyc   = 0;
        bufq.delete();
        last_addr = '0;
        last_data = '0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".Load"},  32'(Load), 0);
        chk({tag, ".wr_en"}, 32'(wr_en), 0);
        chk({tag, ".wr_addr"}, 32'(wr_addr), 0);
        chk({tag, ".wb_alu_data"}, 32'(wb_alu_data), 0);
        chk({tag, ".stall"}, 32'(stall), 0);
    endtask

    // Called right after a negedge: drive one cycle, compare against the model,
    // then advance the model. The caller may add checks before the next negedge.
    task automatic apply(input bit av, input logic [ADDR_W-1:0] aa, input logic [DATA_W-1:0] ad,
                         input bit li, input logic [ADDR_W-1:0] ld,
                         input bit rv, input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        bit                busy, ret, e_stall, alu_ok, ld_ok, e_load, e_wren;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_data;
        wr_t               w;
        alu_wr_valid = av; alu_wr_addr = aa; alu_wr_data = ad;
        load_issue = li;   load_dst = ld;
        rd_valid = rv;     rd_addr_a = ra;  rd_addr_b = rb;
        #2;
        busy    = pend_v;
        ret     = pend_v && (cyc == ret_cyc);
        e_stall = (bufq.size() != 0) ||
                  (busy && (li || (rv && (ra == pend_dst || rb == pend_dst)) || (av && aa == pend_dst)));
        alu_ok  = av && !e_stall;
        ld_ok   = li && !e_stall;
        e_load  = 1'b0;
        e_wren  = 1'b0;
        e_addr  = last_addr;
        e_data  = last_data;
        if (ret) begin
            e_load = 1'b1; e_wren = 1'b1; e_addr = pend_dst;
        end else if (bufq.size() != 0) begin
            e_wren = 1'b1; e_addr = bufq[0].a; e_data = bufq[0].d;
        end else if (alu_ok) begin
            e_wren = 1'b1; e_addr = aa; e_data = ad;
        end
        chk($sformatf("c%0d.stall", cyc), 32'(stall), 32'(e_stall));
        chk($sformatf("c%0d.Load", cyc), 32'(Load), 32'(e_load));
        chk($sformatf("c%0d.wr_en", cyc), 32'(wr_en), 32'(e_wren));
        chk($sformatf("c%0d.wr_addr", cyc), 32'(wr_addr), 32'(e_addr));
        chk($sformatf("c%0d.wb_alu_data", cyc), 32'(wb_alu_data), 32'(e_data));
        if (ret) pend_v = 1'b0;
        if (!ret && bufq.size() != 0) void'(bufq.pop_front());
        if (ret && alu_ok) begin
            w.a = aa; w.d = ad;
            bufq.push_back(w);
        end
        if (ld_ok) begin
            pend_v = 1'b1; pend_dst = ld; ret_cyc = cyc + LOAD_LAT;
        end
        last_addr = e_addr;
        last_data = e_data;
        cyc++;
    endtask

    task automatic idle();
        apply(0, '0, '0, 0, '0, 0, '0, '0);
    endtask

    initial begin
        model_reset();
        #2;
        chk_all_zero("reset");
        @(negedge CLK);
        RST_n = 1'b1;

        // Reset while a load to r3 is in WAIT: nothing is written afterwards.
        apply(0, '0, '0, 1, 3'd3, 0, '0, '0);
        @(negedge CLK);
        alu_wr_valid = 0; load_issue = 0; rd_valid = 0;
        RST_n = 1'b0;
        #2;
        chk_all_zero("rst_wait");
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("rst_wait.no_wr", 32'(wr_en), 0);
            @(negedge CLK);
        end

        // Plain ALU write.
        apply(1, 3'd2, 8'h5A, 0, '0, 0, '0, '0);
        chk("alu.wr_en", 32'(wr_en), 1);
        chk("alu.wr_addr", 32'(wr_addr), 2);
        chk("alu.Load", 32'(Load), 0);
        chk("alu.data", 32'(wb_alu_data), 32'h5A);
        chk("alu.stall", 32'(stall), 0);
        @(negedge CLK);

        // Load r4 returns two cycles later.
        apply(0, '0, '0, 1, 3'd4, 0, '0, '0); @(negedge CLK);
        idle(); @(negedge CLK);
        idle();
        chk("ld.ret_Load", 32'(Load), 1);
        chk("ld.ret_addr", 32'(wr_addr), 4);
        @(negedge CLK);
        idle();
        chk("ld.after_wr_en", 32'(wr_en), 0);
        @(negedge CLK);

        // ALU write colliding with the load return is parked then drained.
        apply(0, '0, '0, 1, 3'd4, 0, '0, '0); @(negedge CLK);
        idle(); @(negedge CLK);
        apply(1, 3'd1, 8'h33, 0, '0, 0, '0, '0);
        chk("col.ret_Load", 32'(Load), 1);
        chk("col.ret_addr", 32'(wr_addr), 4);
        @(negedge CLK);
        idle();
        chk("col.drain_stall", 32'(stall), 1);
        chk("col.drain_Load", 32'(Load), 0);
        chk("col.drain_addr", 32'(wr_addr), 1);
        chk("col.drain_data", 32'(wb_alu_data), 32'h33);
        @(negedge CLK);
        idle();
        chk("col.stall_clear", 32'(stall), 0);
        @(negedge CLK);

        // RAW hazard on r4.
        apply(0, '0, '0, 1, 3'd4, 0, '0, '0); @(negedge CLK);
        apply(0, '0, '0, 0, '0, 1, 3'd0, 3'd4);
        chk("raw.c1", 32'(stall), 1);
        @(negedge CLK);
        apply(0, '0, '0, 0, '0, 1, 3'd0, 3'd4);
        chk("raw.c2", 32'(stall), 1);
        @(negedge CLK);
        apply(0, '0, '0, 0, '0, 1, 3'd0, 3'd4);
        chk("raw.c3", 32'(stall), 0);
        @(negedge CLK);

        // Second load held off until after the first returns.
        apply(0, '0, '0, 1, 3'd4, 0, '0, '0); @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            apply(0, '0, '0, 1, 3'd5, 0, '0, '0);
            if (i < 2) chk("ld2.stall", 32'(stall), 1);
            else       chk("ld2.accept", 32'(stall), 0);
            @(negedge CLK);
        end
        for (int i = 0; i < 3; i++) begin idle(); @(negedge CLK); end

        // WAW: ALU write to r4 waits until after the load write.
        apply(0, '0, '0, 1, 3'd4, 0, '0, '0); @(negedge CLK);
        apply(1, 3'd4, 8'h77, 0, '0, 0, '0, '0);
        chk("waw.c1_stall", 32'(stall), 1);
        chk("waw.c1_wr_en", 32'(wr_en), 0);
        @(negedge CLK);
        apply(1, 3'd4, 8'h77, 0, '0, 0, '0, '0);
        chk("waw.c2_Load", 32'(Load), 1);
        @(negedge CLK);
        apply(1, 3'd4, 8'h77, 0, '0, 0, '0, '0);
        chk("waw.c3_data", 32'(wb_alu_data), 32'h77);
        chk("waw.c3_Load", 32'(Load), 0);
        @(negedge CLK);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply(($urandom % 2) == 0, ADDR_W'($urandom_range(0, 3)), DATA_W'($urandom),
                  ($urandom % 4) == 0, ADDR_W'($urandom_range(0, 3)),
                  ($urandom % 3) == 0, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)));
            @(negedge CLK);
        end
        for (int i = 0; i < 4; i++) begin idle(); @(negedge CLK); end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
